fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Single-clock FIFO controller that sequences the team's dual-port RAM (`Mem`) for same-clock use. It holds both pointers, gates the RAM write and read enables, and keeps occupancy, status flags and sticky error flags. It works for any depth up to 2^N, including non-power-of-2 depths. Both of the RAM's clock inputs are tied to this block's `clk`.

## Interface
- `N`, 8, pointer width; must equal RAM `N`.
- `DEPTH`, 90, number of entries; 2 ≤ DEPTH ≤ 2^N; must equal RAM `depth`.
- `AF_LEVEL`, DEPTH-4, `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 4, `almost_empty` asserts when count ≤ AE_LEVEL.

Ports:
- `clk` in 1: single clock for this block and both RAM ports.
- `rst_n` in 1: reset, asynchronous, active-low.
- `push` in 1: write request; data is presented to the RAM in the same cycle.
- `pop` in 1: read request.
- `clear` in 1: synchronous flush.
- `mem_wr_en` out 1: RAM write enable (combinational).
- `mem_wr_ptr` out N: RAM write address (registered).
- `mem_rd_en` out 1: RAM read enable (combinational).
- `mem_rd_ptr` out N: RAM read address (registered).
- `rd_valid` out 1: RAM `rd_data` is valid this cycle.
- `count` out N+1: occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty` out 1 each: registered status flags.
- `overflow`, `underflow` out 1 each: sticky error flags.

## Operation
- Acceptance rules:
  - `pop_acc = pop & ~empty & ~clear`.
  - `push_acc = push & ~clear & (~full | pop_acc)`.
  - A push while full is accepted only together with an accepted pop. Both RAM ports then address the same entry; the RAM's read returns the old data.
  - A push and pop while empty: the push is accepted and the pop is rejected.
- RAM drive: `mem_wr_en = push_acc`, `mem_rd_en = pop_acc`.
- Pointers:
  - `wr_ptr` advances on `push_acc`; `rd_ptr` advances on `pop_acc`.
  - Wrap rule: if ptr == DEPTH-1 the next value is 0, otherwise ptr+1. This is not a binary rollover.
- Count:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - It never leaves 0..DEPTH.
- Flags are computed from the next count and registered:
  - `full` = (count == DEPTH); `empty` = (count == 0).
  - `almost_full` and `almost_empty` follow the levels given under Interface.
- Error flags:
  - `overflow` sets on `push & ~push_acc & ~clear`.
  - `underflow` sets on `pop & ~pop_acc & ~clear`.
  - Both hold until `clear` or reset.
- `clear`:
  - Takes priority over push and pop in the same cycle; both RAM enables are forced to 0.
  - Next cycle: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0.
  - RAM contents are not cleared.
- No state machine beyond the pointer, count and flag registers. The implementation must not derive full/empty by comparing pointers.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - ptrs=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0.
  - Combinational enables are 0 while in reset.
- Write latency: an accepted push in cycle T is counted in `count` and the flags at T+1. The data is in RAM at T+1.
- Read latency: an accepted pop in cycle T gives `rd_valid`=1 in T+1, aligned with RAM `rd_data`. `rd_valid` is exactly one cycle per accepted pop, so back-to-back pops give continuous `rd_valid`.
- Reset mid-stream: all state returns to reset values immediately. A pending `rd_valid` is dropped.
- Flags are settled one cycle after the causing edge. Producers and consumers may sample `full`/`empty` combinationally for the next request.

## Test plan
- Reset, then 90 consecutive pushes (data 0..89):
  - `almost_full` rises when count reaches 86.
  - `full` rises after the 90th push.
  - A 91st push sets `overflow`, and `mem_wr_en` stays 0.
- Drain 90 pops:
  - `rd_valid` pulses 90 cycles, with data 0..89 in order.
  - `almost_empty` is seen at count 4; `empty` at count 0.
  - A further pop sets `underflow`.
- Wrap-around: 200 interleaved push/pop pairs with count held near 10.
  - `mem_wr_ptr` goes 89→0 and `mem_rd_ptr` goes 89→0.
  - No flag glitches; data order is preserved.
- Simultaneous push and pop:
  - At full: both accepted, count stays 90, returned data is the oldest entry, no overflow.
  - At empty: only the push is accepted, count 0→1, and `underflow` sets.
- `clear` asserted together with push and pop at count 37:
  - No RAM enables in that cycle.
  - Next cycle: count 0, empty 1, and the sticky flags are cleared.
- `rst_n` dropped asynchronously in the middle of a cycle at count 50 with a pop outstanding:
  - All outputs take reset values immediately.
  - `rd_valid` stays 0 after release.
  - The first push after release goes to address 0.

Source files
------------

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Brief    : Single-clock FIFO controller sequencing a dual-port RAM;
//            wrap-at-DEPTH pointers, occupancy count, status and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int N        = 8,
  parameter int DEPTH    = 90,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  output logic         mem_wr_en,
  output logic [N-1:0] mem_wr_ptr,
  output logic         mem_rd_en,
  output logic [N-1:0] mem_rd_ptr,
  output logic         rd_valid,
  output logic [N:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [N:0]   c_DEPTH = (N+1)'(DEPTH);
  localparam logic [N:0]   c_AF    = (N+1)'(AF_LEVEL);
  localparam logic [N:0]   c_AE    = (N+1)'(AE_LEVEL);
  localparam logic [N-1:0] c_LAST  = N'(DEPTH - 1);

  logic [N-1:0] r_wr_ptr, r_rd_ptr;
  logic [N:0]   r_count, w_count_nxt;
  logic         r_full, r_empty, r_af, r_ae;
  logic         r_overflow, r_underflow, r_rd_valid;
  logic         w_push_acc, w_pop_acc;

  // Depth need not be a power of two, so the pointer wraps explicitly.
  function automatic logic [N-1:0] f_ptr_inc(input logic [N-1:0] p);
    return (p == c_LAST) ? '0 : p + N'(1);
  endfunction

  // rst_n gating keeps both RAM enables low for the whole reset window.
  assign w_pop_acc  = rst_n & pop & ~r_empty & ~clear;
  assign w_push_acc = rst_n & push & ~clear & (~r_full | w_pop_acc);

  always_comb begin
    w_count_nxt = r_count;
    if (clear)
      w_count_nxt = '0;
    else if (w_push_acc && !w_pop_acc)
      w_count_nxt = r_count + (N+1)'(1);
    else if (w_pop_acc && !w_push_acc)
      w_count_nxt = r_count - (N+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == c_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      r_af       <= (w_count_nxt >= c_AF);
      r_ae       <= (w_count_nxt <= c_AE);
      r_rd_valid <= w_pop_acc;
      if (clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_push_acc) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
        if (w_pop_acc)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
        r_overflow  <= r_overflow  | (push & ~w_push_acc);
        r_underflow <= r_underflow | (pop  & ~w_pop_acc);
      end
    end
  end

  assign mem_wr_en    = w_push_acc;
  assign mem_rd_en    = w_pop_acc;
  assign mem_wr_ptr   = r_wr_ptr;
  assign mem_rd_ptr   = r_rd_ptr;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Brief    : Directed self-checking bench for fifo_ctrl with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push, pop, clear;
  logic       mem_wr_en, mem_rd_en, rd_valid;
  logic [7:0] mem_wr_ptr, mem_rd_ptr;
  logic [8:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0] wdata, rd_data;
  logic [7:0] ram [0:255];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  logic [7:0] dcnt;
  logic [7:0] e_wr, e_rd, prev_wr, prev_rd;
  logic       seen_wr_wrap, seen_rd_wrap;

  fifo_ctrl #(.N(8), .DEPTH(90), .AF_LEVEL(86), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clear(clear),
    .mem_wr_en(mem_wr_en), .mem_wr_ptr(mem_wr_ptr),
    .mem_rd_en(mem_rd_en), .mem_rd_ptr(mem_rd_ptr),
    .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM: a same-address read returns the old entry.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_ptr] <= wdata;
    if (mem_rd_en) rd_data <= ram[mem_rd_ptr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] p);
    return (p == 8'd89) ? 8'd0 : p + 8'd1;
  endfunction

  // Called at posedge+1; inputs settle for 2 time units before comb checks.
  task automatic drive(input logic p, input logic q, input logic c, input logic [7:0] d);
    push = p; pop = q; clear = c; wdata = d;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_ae"}, almost_empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_af"}, almost_full, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_unf"}, underflow, 0);
    check({tag, "_rdv"}, rd_valid, 0);
    check({tag, "_wptr"}, mem_wr_ptr, 0);
    check({tag, "_rptr"}, mem_rd_ptr, 0);
  endtask

  initial begin
    rst_n = 1'b0; push = 0; pop = 0; clear = 0; wdata = 0;
    step();
    check_idle_reset("reset");
    push = 1'b1; #1;
    check("reset_wr_en_gated", mem_wr_en, 0);
    push = 1'b0;
    rst_n = 1'b1;
    step();

    // Fill with 0..89.
    for (int i = 0; i < 90; i++) begin
      drive(1, 0, 0, 8'(i));
      check("fill_wr_en", mem_wr_en, 1);
      step();
      check("fill_count", count, i + 1);
      check("fill_af", almost_full, (i + 1 >= 86) ? 1 : 0);
      check("fill_full", full, (i + 1 == 90) ? 1 : 0);
    end
    check("fill_wptr_wrapped", mem_wr_ptr, 0);
    drive(1, 0, 0, 8'd200);
    check("ovf_wr_en", mem_wr_en, 0);
    step();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 90);

    // Drain, expecting 0..89 in order.
    for (int i = 0; i < 90; i++) begin
      drive(0, 1, 0, 8'd0);
      check("drain_rd_en", mem_rd_en, 1);
      step();
      check("drain_rdv", rd_valid, 1);
      check("drain_data", rd_data, i);
      check("drain_count", count, 89 - i);
      check("drain_ae", almost_empty, (89 - i <= 4) ? 1 : 0);
      check("drain_empty", empty, (i == 89) ? 1 : 0);
    end
    drive(0, 1, 0, 8'd0);
    check("unf_rd_en", mem_rd_en, 0);
    step();
    check("unf_set", underflow, 1);
    check("unf_rdv", rd_valid, 0);
    check("ovf_sticky", overflow, 1);

    drive(0, 0, 1, 8'd0);
    step();
    check_idle_reset("clr1");

    // Wrap-around at steady occupancy of 10.
    dcnt = 8'd100; e_wr = 0; e_rd = 0; seen_wr_wrap = 0; seen_rd_wrap = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, dcnt);
      sb.push_back(dcnt); dcnt++; e_wr = nxt(e_wr);
      step();
    end
    check("wrap_pre_count", count, 10);
    for (int i = 0; i < 200; i++) begin
      drive(1, 1, 0, dcnt);
      check("wrap_wr_en", mem_wr_en, 1);
      check("wrap_rd_en", mem_rd_en, 1);
      sb.push_back(dcnt); dcnt++;
      prev_wr = mem_wr_ptr; prev_rd = mem_rd_ptr;
      e_wr = nxt(e_wr); e_rd = nxt(e_rd);
      step();
      if (prev_wr == 8'd89 && mem_wr_ptr == 8'd0) seen_wr_wrap = 1;
      if (prev_rd == 8'd89 && mem_rd_ptr == 8'd0) seen_rd_wrap = 1;
      check("wrap_rdv", rd_valid, 1);
      check("wrap_data", rd_data, sb.pop_front());
      check("wrap_count", count, 10);
      check("wrap_flags", {full, empty, almost_full, almost_empty, overflow, underflow}, 6'b0);
      check("wrap_wptr", mem_wr_ptr, e_wr);
      check("wrap_rptr", mem_rd_ptr, e_rd);
    end
    check("wrap_wr_seen", seen_wr_wrap, 1);
    check("wrap_rd_seen", seen_rd_wrap, 1);

    // Fill to full, then push and pop together.
    for (int i = 0; i < 80; i++) begin
      drive(1, 0, 0, dcnt);
      sb.push_back(dcnt); dcnt++;
      step();
    end
    check("full_reached", full, 1);
    drive(1, 1, 0, dcnt);
    check("full_both_wr", mem_wr_en, 1);
    check("full_both_rd", mem_rd_en, 1);
    check("full_same_addr", mem_wr_ptr, mem_rd_ptr);
    sb.push_back(dcnt); dcnt++;
    step();
    check("full_both_count", count, 90);
    check("full_both_data", rd_data, sb.pop_front());
    check("full_both_full", full, 1);
    check("full_both_ovf", overflow, 0);

    drive(0, 0, 1, 8'd0);
    sb.delete();
    step();
    check_idle_reset("clr2");

    // Push and pop while empty: only the push lands.
    drive(1, 1, 0, 8'd7);
    check("empty_both_wr", mem_wr_en, 1);
    check("empty_both_rd", mem_rd_en, 0);
    step();
    check("empty_both_count", count, 1);
    check("empty_both_unf", underflow, 1);
    check("empty_both_rdv", rd_valid, 0);
    check("empty_both_empty", empty, 0);

    // Clear with push and pop at count 37; underflow is still set.
    for (int i = 0; i < 36; i++) begin
      drive(1, 0, 0, 8'(i));
      step();
    end
    check("c37_count", count, 37);
    drive(1, 1, 1, 8'd0);
    check("c37_wr_en", mem_wr_en, 0);
    check("c37_rd_en", mem_rd_en, 0);
    step();
    drive(0, 0, 0, 8'd0);
    check_idle_reset("c37");

    // Asynchronous reset mid-cycle at count 50 with a read in flight.
    for (int i = 0; i < 50; i++) begin
      drive(1, 0, 0, 8'(i));
      step();
    end
    check("r50_count", count, 50);
    drive(0, 1, 0, 8'd0);
    step();
    check("r50_rdv_pending", rd_valid, 1);
    push = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset("async");
    check("async_wr_en", mem_wr_en, 0);
    check("async_rd_en", mem_rd_en, 0);
    push = 1'b0; pop = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_rdv", rd_valid, 0);
    check("post_rst_count", count, 0);
    drive(1, 0, 0, 8'd55);
    check("post_rst_addr", mem_wr_ptr, 0);
    check("post_rst_wr_en", mem_wr_en, 1);
    step();
    drive(0, 0, 0, 8'd0);
    check("post_rst_count1", count, 1);
    check("post_rst_wptr1", mem_wr_ptr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
